// File: rtl/sort_pkg.sv
// Shared definitions for the 4-entry sequential sorter: FSM encoding,
// the compare-swap network length and the step-to-register-pair table.
package sort_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SORT   = 2'd1,
    ST_STREAM = 2'd2,
    ST_FIN    = 2'd3
  } state_e;

  localparam int         NUM_STEPS = 6;
  localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);

  // Pair table, step 0 in the low bits: (0,1) (1,2) (2,3) (0,1) (1,2) (0,1)
  localparam logic [11:0] STEP_LO = {2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0};
  localparam logic [11:0] STEP_HI = {2'd1, 2'd2, 2'd1, 2'd3, 2'd2, 2'd1};

  function automatic logic [1:0] pair_lo(input logic [2:0] step);
    return STEP_LO[{step, 1'b0} +: 2];
  endfunction

  function automatic logic [1:0] pair_hi(input logic [2:0] step);
    return STEP_HI[{step, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/sort4_seq_cmp_swap.sv
// Combinational n-bit unsigned compare-swap. LO goes to the lower register
// index, HI to the upper. Ties pass straight through so the network is stable.
// Build option: SORT_DESCEND_EN flips the order (LO receives the larger value).
module cmp_swap #(
  parameter int n = 8
) (
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  output logic [n-1:0] LO,
  output logic [n-1:0] HI
);

  logic swap;

  // Decide whether the pair is out of order, then route accordingly.
  always_comb begin
    swap = 1'b0;
`ifdef SORT_DESCEND_EN
    swap = (A < B);
`else
    swap = (A > B);
`endif
    LO = swap ? B : A;
    HI = swap ? A : B;
  end

endmodule

// File: rtl/sort4_seq.sv
// Sequential 4-entry sorter: load four operands, run a 6-step compare-swap
// network one step per clock, then stream the sorted registers to the
// downstream 4:1 mux with SEL 0..3 and VALID, followed by a DONE pulse.
// Build option: SORT_DESCEND_EN selects descending order (see cmp_swap).
module sort4_seq
  import sort_pkg::*;
#(
  parameter int n = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         START,
  input  logic [n-1:0] DIN0,
  input  logic [n-1:0] DIN1,
  input  logic [n-1:0] DIN2,
  input  logic [n-1:0] DIN3,
  output logic [n-1:0] S0,
  output logic [n-1:0] S1,
  output logic [n-1:0] S2,
  output logic [n-1:0] S3,
  output logic [1:0]   SEL,
  output logic         VALID,
  output logic         BUSY,
  output logic         DONE
);

  state_e       state_q;
  logic [2:0]   step_q;
  logic [n-1:0] s_q [4];
  logic [1:0]   sel_q;
  logic         valid_q;
  logic         busy_q;
  logic         done_q;

  logic [1:0]   lo_idx;
  logic [1:0]   hi_idx;
  logic [n-1:0] cmp_a;
  logic [n-1:0] cmp_b;
  logic [n-1:0] cmp_lo;
  logic [n-1:0] cmp_hi;

  // The single comparator is steered to the pair selected by the step index.
  assign lo_idx = pair_lo(step_q);
  assign hi_idx = pair_hi(step_q);
  assign cmp_a  = s_q[lo_idx];
  assign cmp_b  = s_q[hi_idx];

  cmp_swap #(.n(n)) u_cmp_swap (
    .A  (cmp_a),
    .B  (cmp_b),
    .LO (cmp_lo),
    .HI (cmp_hi)
  );

  // Sequencer: load, sort, stream, finish; all outputs are registered here.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      for (int i = 0; i < 4; i++) s_q[i] <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (START) begin
            s_q[0]  <= DIN0;
            s_q[1]  <= DIN1;
            s_q[2]  <= DIN2;
            s_q[3]  <= DIN3;
            step_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SORT;
          end
        end
        ST_SORT: begin
          s_q[lo_idx] <= cmp_lo;
          s_q[hi_idx] <= cmp_hi;
          if (step_q == LAST_STEP) begin
            step_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b1;
            state_q <= ST_STREAM;
          end else begin
            step_q <= step_q + 3'd1;
          end
        end
        ST_STREAM: begin
          if (sel_q == 2'd3) begin
            sel_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_FIN;
          end else begin
            sel_q <= sel_q + 2'd1;
          end
        end
        ST_FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign S0    = s_q[0];
  assign S1    = s_q[1];
  assign S2    = s_q[2];
  assign S3    = s_q[3];
  assign SEL   = sel_q;
  assign VALID = valid_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;

endmodule
